adaptive_step_ctrl: RTL and testbench
=====================================

ADAPTIVE_STEP_CTRL -- requirements
Module: adaptive_step_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, width of all signed two's-complement fixed-point data.
REQ-002 Parameter FRAC, default 8, fractional bits; 1.0 = 2^FRAC.
REQ-003 Parameter N_CH, default 2, number of solution components checked per step.
REQ-004 Parameter MAX_REJ, default 4, consecutive rejections before exception.
REQ-005 Parameter GROW_SHIFT, default 4, growth threshold: grow h when err <= tol>>GROW_SHIFT.
REQ-006 Clk  in  1  sole clock; all state changes on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  begin one step evaluation; sampled in IDLE only.
REQ-009 h_load  in  1  load h_in into step register; IDLE only.
REQ-010 h_in  in  WIDTH  initial step value.
REQ-011 coarse_in  in  N_CH*WIDTH  full-step estimates, channel k at bits [k*WIDTH +: WIDTH].
REQ-012 fine_in  in  N_CH*WIDTH  two-half-step estimates, same packing.
REQ-013 tol_in, h_min, h_max  in  WIDTH each  tolerance, lower step bound, upper step bound.
REQ-014 busy  out  1  high outside IDLE.
REQ-015 done  out  1  one-cycle pulse when a decision is complete.
REQ-016 accept  out  1  decision of last evaluation, valid from done onward.
REQ-017 inc_time  out  1  one-cycle pulse coincident with done when accept=1.
REQ-018 h_out  out  WIDTH  current step register.
REQ-019 err_max  out  WIDTH  max |coarse-fine| over channels of last evaluation.
REQ-020 exc  out  3  sticky exceptions: [0] arithmetic overflow, [1] h clamped at h_min, [2] reject limit hit.

Function
REQ-021 FSM states IDLE, ACCUM, DECIDE, DONE; IDLE->ACCUM on start (h_load low); ACCUM->DECIDE after channel N_CH-1; DECIDE->DONE; DONE->IDLE unconditionally.
REQ-022 On accepted start: coarse_in, fine_in, tol_in, h_min, h_max latched; channel index and running max cleared to 0.
REQ-023 ACCUM: one channel per cycle; diff = coarse-fine at WIDTH+1 bits; |diff| > max positive WIDTH value saturates to 2^(WIDTH-1)-1 and sets exc[0].
REQ-024 Running max updated with unsigned compare of |diff|; err_max register written at ACCUM exit.
REQ-025 Latency: start at cycle t -> done high at cycle t+N_CH+2; busy high cycles t+1..t+N_CH+2.
REQ-026 DECIDE reject when err_max > tol: h_next = h>>>1; reject counter +1; accept=0.
REQ-027 Reject clamp: if h_next < h_min then h_next = h_min and exc[1] set.
REQ-028 Reject counter reaching MAX_REJ sets exc[2]; counter saturates at MAX_REJ.
REQ-029 DECIDE accept when err_max <= tol: reject counter cleared; accept=1.
REQ-030 Accept growth: if err_max <= tol>>>GROW_SHIFT then h_next = min(h<<1, h_max); if h<<1 overflows WIDTH, h_next = h_max (no exception); otherwise h unchanged.
REQ-031 Negative tol_in treated as tol=0 and sets exc[0].
REQ-032 h register updated on DECIDE->DONE edge; h_out reflects new value when done is high.
REQ-033 start or h_load outside IDLE ignored; h_load and start same IDLE cycle: load performed, start ignored.
REQ-034 accept and err_max hold until next DONE; exc bits hold until reset.

Reset
REQ-035 reset=1 at any edge forces IDLE, busy=0, done=0, inc_time=0, accept=0, err_max=0, exc=0, reject counter=0, h_out=0, including mid-ACCUM/DECIDE with no partial h update.

Verification (WIDTH=16, FRAC=8, N_CH=2, MAX_REJ=4, GROW_SHIFT=4)
REQ-036 h_load h_in=0x0100; coarse={0x0210,0x0100}, fine={0x0200,0x0100}, tol=0x0020 -> done at t+4, err_max=0x0010, accept=1, inc_time pulse, h_out=0x0100.
REQ-037 Same h, diffs 0x0001, tol=0x0020, h_max=0x0180 -> accept=1, h_out=0x0180 (growth clamped).
REQ-038 h=0x0100, diff 0x0040, tol=0x0020, h_min=0x0010, five consecutive starts -> h 0x0080,0x0040,0x0020,0x0010,0x0010; exc[1]=1 at fifth; exc[2]=1 from fourth done.
REQ-039 coarse=0x7FFF, fine=0x8000 -> err_max=0x7FFF, exc[0]=1, accept=0.
REQ-040 reset asserted cycle t+2 of a rejecting evaluation -> next cycle IDLE, h_out=0, no done pulse; start pulses during busy produce no extra done.

Source files
------------

// File: rtl/adaptive_step_ctrl.sv
// Adaptive step-size controller: compares full-step and two-half-step estimates
// per channel, then accepts/rejects the step and grows or halves h accordingly.
module adaptive_step_ctrl #(
   parameter int WIDTH      = 16,
   parameter int FRAC       = 8,
   parameter int N_CH       = 2,
   parameter int MAX_REJ    = 4,
   parameter int GROW_SHIFT = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    h_load,
   input  logic [WIDTH-1:0]        h_in,
   input  logic [N_CH*WIDTH-1:0]   coarse_in,
   input  logic [N_CH*WIDTH-1:0]   fine_in,
   input  logic [WIDTH-1:0]        tol_in,
   input  logic [WIDTH-1:0]        h_min,
   input  logic [WIDTH-1:0]        h_max,
   output logic                    busy,
   output logic                    done,
   output logic                    accept,
   output logic                    inc_time,
   output logic [WIDTH-1:0]        h_out,
   output logic [WIDTH-1:0]        err_max,
   output logic [2:0]              exc
);

   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int RW = $clog2(MAX_REJ + 1);
   localparam logic [WIDTH:0]   MAX_POS   = {2'b00, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_VAL   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [RW-1:0]    REJ_LIMIT = RW'(MAX_REJ);

   // Fixed-point scaling is implicit; FRAC only has to leave at least one integer bit.
   if (FRAC >= WIDTH || WIDTH < 2 || N_CH < 1 || MAX_REJ < 1) begin : gBadParams
      $error("adaptive_step_ctrl: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, DONE} stateT;

   stateT state, stateNext;

   logic [N_CH*WIDTH-1:0]     coarseReg, fineReg;
   logic [WIDTH-1:0]          tolReg;
   logic signed [WIDTH-1:0]   hReg, hMinReg, hMaxReg;
   logic [CW-1:0]             chIdx;
   logic [WIDTH-1:0]          curMax, errReg;
   logic [RW-1:0]             rejCnt;
   logic                      acceptReg;
   logic [2:0]                excReg;

   logic                      lastCh;
   logic signed [WIDTH-1:0]   cSel, fSel;
   logic signed [WIDTH:0]     diff;
   logic [WIDTH:0]            absDiff;
   logic                      absOvf;
   logic [WIDTH-1:0]          absSat, maxNext;

   logic                      reject, growOk, clampHit, dblOvf, limitHit;
   logic signed [WIDTH-1:0]   hHalf, hDouble, hNext;
   logic [RW-1:0]             rejNext;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state and handshake outputs; a load request in IDLE takes priority over start
   always_comb begin
      stateNext = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start && !h_load) stateNext = ACCUM;
         end
         ACCUM:   if (lastCh) stateNext = DECIDE;
         DECIDE:  stateNext = DONE;
         DONE: begin
            done      = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Per-channel error: difference at one extra bit, magnitude saturated to max positive
   always_comb begin
      lastCh  = (chIdx == CW'(N_CH - 1));
      cSel    = coarseReg[chIdx*WIDTH +: WIDTH];
      fSel    = fineReg[chIdx*WIDTH +: WIDTH];
      diff    = {cSel[WIDTH-1], cSel} - {fSel[WIDTH-1], fSel};
      absDiff = diff[WIDTH] ? -diff : diff;
      absOvf  = (absDiff > MAX_POS);
      absSat  = absOvf ? SAT_VAL : absDiff[WIDTH-1:0];
      maxNext = (absSat > curMax) ? absSat : curMax;
   end

   // Step decision: halve on reject (bounded by h_min), double on a comfortably small error
   always_comb begin
      reject   = (errReg > tolReg);
      growOk   = (errReg <= (tolReg >> GROW_SHIFT));
      hHalf    = hReg >>> 1;
      hDouble  = hReg <<< 1;
      dblOvf   = (hReg[WIDTH-1] != hReg[WIDTH-2]);
      clampHit = reject && (hHalf < hMinReg);
      hNext    = hReg;
      rejNext  = '0;
      if (reject) begin
         hNext   = clampHit ? hMinReg : hHalf;
         rejNext = (rejCnt == REJ_LIMIT) ? rejCnt : rejCnt + RW'(1);
      end else if (growOk) begin
         if (dblOvf || (hDouble > hMaxReg)) hNext = hMaxReg;
         else                               hNext = hDouble;
      end
      limitHit = reject && (rejNext == REJ_LIMIT);
   end

   // Datapath registers; tolerance is stored already clamped to be non-negative
   always_ff @(posedge clk) begin
      if (reset) begin
         coarseReg <= '0;
         fineReg   <= '0;
         tolReg    <= '0;
         hReg      <= '0;
         hMinReg   <= '0;
         hMaxReg   <= '0;
         chIdx     <= '0;
         curMax    <= '0;
         errReg    <= '0;
         rejCnt    <= '0;
         acceptReg <= 1'b0;
         excReg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (h_load) begin
                  hReg <= $signed(h_in);
               end else if (start) begin
                  coarseReg <= coarse_in;
                  fineReg   <= fine_in;
                  hMinReg   <= $signed(h_min);
                  hMaxReg   <= $signed(h_max);
                  chIdx     <= '0;
                  curMax    <= '0;
                  if (tol_in[WIDTH-1]) begin
                     tolReg    <= '0;
                     excReg[0] <= 1'b1;
                  end else begin
                     tolReg <= tol_in;
                  end
               end
            end
            ACCUM: begin
               curMax <= maxNext;
               chIdx  <= chIdx + CW'(1);
               if (absOvf) excReg[0] <= 1'b1;
               if (lastCh) errReg <= maxNext;
            end
            DECIDE: begin
               hReg      <= hNext;
               acceptReg <= !reject;
               rejCnt    <= rejNext;
               if (clampHit) excReg[1] <= 1'b1;
               if (limitHit) excReg[2] <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign accept   = acceptReg;
   assign inc_time = done & acceptReg;
   assign h_out    = hReg;
   assign err_max  = errReg;
   assign exc      = excReg;

endmodule

// File: tb/tb_adaptive_step_ctrl.sv
// Bench for adaptive_step_ctrl: arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed expected values.
module tb_adaptive_step_ctrl;

   localparam int WIDTH      = 16;
   localparam int FRAC       = 8;
   localparam int N_CH       = 2;
   localparam int MAX_REJ    = 4;
   localparam int GROW_SHIFT = 4;
   localparam int MAXPOS     = (1 << (WIDTH - 1)) - 1;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  start = 1'b0;
   logic                  hLoad = 1'b0;
   logic [WIDTH-1:0]      hIn = '0;
   logic [N_CH*WIDTH-1:0] coarseIn = '0;
   logic [N_CH*WIDTH-1:0] fineIn = '0;
   logic [WIDTH-1:0]      tolIn = '0;
   logic [WIDTH-1:0]      hMin = '0;
   logic [WIDTH-1:0]      hMax = '0;
   logic                  busy, done, accept, incTime;
   logic [WIDTH-1:0]      hOut, errMax;
   logic [2:0]            exc;

   int total = 0;
   int bad = 0;
   bit cmpEn = 1'b0;

   adaptive_step_ctrl #(
      .WIDTH(WIDTH), .FRAC(FRAC), .N_CH(N_CH), .MAX_REJ(MAX_REJ), .GROW_SHIFT(GROW_SHIFT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .h_load(hLoad), .h_in(hIn),
      .coarse_in(coarseIn), .fine_in(fineIn), .tol_in(tolIn), .h_min(hMin), .h_max(hMax),
      .busy(busy), .done(done), .accept(accept), .inc_time(incTime),
      .h_out(hOut), .err_max(errMax), .exc(exc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int       err;
      bit       acc;
      int       h;
      bit [2:0] exc;
      int       rej;
   } resT;

   // Model state: cnt counts remaining busy cycles, results become visible in the done cycle
   int       cnt = 0;
   int       hM = 0;
   int       errM = 0;
   int       rejM = 0;
   bit       accM = 1'b0;
   bit [2:0] excM = '0;
   resT      pend;

   function automatic logic [31:0] toW(input int v);
      return 32'(v) & ((32'd1 << WIDTH) - 32'd1);
   endfunction

   function automatic int sx(input logic [WIDTH-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic resT modelEval(input int hCur, input int rejCur, input bit [2:0] excCur);
      resT r;
      int  err, a, tol, dbl, lo, hi;
      r.exc = excCur;
      err = 0;
      for (int k = 0; k < N_CH; k++) begin
         a = sx(coarseIn[k*WIDTH +: WIDTH]) - sx(fineIn[k*WIDTH +: WIDTH]);
         if (a < 0) a = -a;
         if (a > MAXPOS) begin
            a = MAXPOS;
            r.exc[0] = 1'b1;
         end
         if (a > err) err = a;
      end
      tol = sx(tolIn);
      if (tol < 0) begin
         tol = 0;
         r.exc[0] = 1'b1;
      end
      lo = sx(hMin);
      hi = sx(hMax);
      r.err = err;
      r.h = hCur;
      if (err > tol) begin
         r.acc = 1'b0;
         r.h = hCur >>> 1;
         if (r.h < lo) begin
            r.h = lo;
            r.exc[1] = 1'b1;
         end
         r.rej = (rejCur < MAX_REJ) ? rejCur + 1 : MAX_REJ;
         if (r.rej >= MAX_REJ) r.exc[2] = 1'b1;
      end else begin
         r.acc = 1'b1;
         r.rej = 0;
         if (err <= (tol >>> GROW_SHIFT)) begin
            dbl = hCur * 2;
            if (dbl > MAXPOS || dbl < -MAXPOS - 1) r.h = hi;
            else                                   r.h = (dbl > hi) ? hi : dbl;
         end
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         cnt  <= 0;
         hM   <= 0;
         errM <= 0;
         rejM <= 0;
         accM <= 1'b0;
         excM <= '0;
      end else if (cnt == 0) begin
         if (hLoad) begin
            hM <= sx(hIn);
         end else if (start) begin
            pend <= modelEval(hM, rejM, excM);
            cnt  <= N_CH + 2;
         end
      end else begin
         cnt <= cnt - 1;
         if (cnt == 2) begin
            hM   <= pend.h;
            errM <= pend.err;
            accM <= pend.acc;
            excM <= pend.exc;
            rejM <= pend.rej;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model; result registers only when settled
   always @(negedge clk) begin
      if (cmpEn) begin
         checkOutput("busy", 32'(busy), 32'(cnt != 0));
         checkOutput("done", 32'(done), 32'(cnt == 1));
         checkOutput("incTime", 32'(incTime), 32'((cnt == 1) && accM));
         if (cnt <= 1) begin
            checkOutput("hOut", 32'(hOut), toW(hM));
            checkOutput("errMax", 32'(errMax), toW(errM));
            checkOutput("accept", 32'(accept), 32'(accM));
            checkOutput("exc", 32'(exc), 32'(excM));
         end
      end
   end

   task automatic applyStimulus(input bit st, input bit ld, input logic [WIDTH-1:0] h,
                                input logic [N_CH*WIDTH-1:0] c, input logic [N_CH*WIDTH-1:0] f,
                                input logic [WIDTH-1:0] tol, input logic [WIDTH-1:0] lo,
                                input logic [WIDTH-1:0] hi);
      @(posedge clk);
      #1;
      hIn = h;
      coarseIn = c;
      fineIn = f;
      tolIn = tol;
      hMin = lo;
      hMax = hi;
      start = st;
      hLoad = ld;
      @(posedge clk);
      #1;
      start = 1'b0;
      hLoad = 1'b0;
   endtask

   task automatic waitDone(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (done !== 1'b1 && cyc < 20);
      #1;
      checkOutput("doneSeen", 32'(done), 32'd1);
      checkOutput("latency", 32'(cyc), 32'(N_CH + 2));
   endtask

   logic [WIDTH-1:0] hSeq [5];
   bit               exc1Seq [5];
   bit               exc2Seq [5];

   initial begin
      int cyc;
      int doneCount;
      hSeq    = '{16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0010};
      exc1Seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      exc2Seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cmpEn = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstH", 32'(hOut), 32'd0);
      checkOutput("rstExc", 32'(exc), 32'd0);
      checkOutput("rstErr", 32'(errMax), 32'd0);

      $display("[TB] basic accept without growth");
      applyStimulus(0, 1, 16'h0100, '0, '0, '0, '0, '0);
      applyStimulus(1, 0, 16'h0000, {16'h0210, 16'h0100}, {16'h0200, 16'h0100},
                    16'h0020, 16'h0010, 16'h7000);
      waitDone(cyc);
      checkOutput("t1Err", 32'(errMax), 32'h0010);
      checkOutput("t1Acc", 32'(accept), 32'd1);
      checkOutput("t1Inc", 32'(incTime), 32'd1);
      checkOutput("t1H", 32'(hOut), 32'h0100);
      checkOutput("t1ModelH", toW(hM), 32'h0100);
      checkOutput("t1Exc", 32'(exc), 32'd0);

      $display("[TB] growth clamped at h_max");
      applyStimulus(1, 0, 16'h0000, {16'h0051, 16'h0101}, {16'h0050, 16'h0100},
                    16'h0020, 16'h0010, 16'h0180);
      waitDone(cyc);
      checkOutput("t2Err", 32'(errMax), 32'h0001);
      checkOutput("t2Acc", 32'(accept), 32'd1);
      checkOutput("t2H", 32'(hOut), 32'h0180);

      $display("[TB] consecutive rejections down to h_min");
      applyStimulus(0, 1, 16'h0100, '0, '0, '0, '0, '0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 16'h0000, {16'h0000, 16'h0140}, {16'h0000, 16'h0100},
                       16'h0020, 16'h0010, 16'h7000);
         waitDone(cyc);
         checkOutput($sformatf("t3H%0d", i), 32'(hOut), 32'(hSeq[i]));
         checkOutput($sformatf("t3Acc%0d", i), 32'(accept), 32'd0);
         checkOutput($sformatf("t3Inc%0d", i), 32'(incTime), 32'd0);
         checkOutput($sformatf("t3Exc1_%0d", i), 32'(exc[1]), 32'(exc1Seq[i]));
         checkOutput($sformatf("t3Exc2_%0d", i), 32'(exc[2]), 32'(exc2Seq[i]));
      end

      $display("[TB] saturating difference");
      applyStimulus(1, 0, 16'h0000, {16'h0000, 16'h7FFF}, {16'h0000, 16'h8000},
                    16'h0020, 16'h0010, 16'h7000);
      waitDone(cyc);
      checkOutput("t4Err", 32'(errMax), 32'h7FFF);
      checkOutput("t4Exc", 32'(exc), 32'h7);
      checkOutput("t4Acc", 32'(accept), 32'd0);
      checkOutput("t4H", 32'(hOut), 32'h0010);

      $display("[TB] doubling overflow falls back to h_max");
      applyStimulus(0, 1, 16'h5000, '0, '0, '0, '0, '0);
      applyStimulus(1, 0, 16'h0000, '0, '0, 16'h0020, 16'h0010, 16'h7000);
      waitDone(cyc);
      checkOutput("t5H", 32'(hOut), 32'h7000);
      checkOutput("t5Acc", 32'(accept), 32'd1);

      $display("[TB] reset during evaluation");
      applyStimulus(0, 1, 16'h0100, '0, '0, '0, '0, '0);
      applyStimulus(1, 0, 16'h0000, {16'h0000, 16'h0140}, {16'h0000, 16'h0100},
                    16'h0020, 16'h0010, 16'h7000);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rBusy", 32'(busy), 32'd0);
      checkOutput("rH", 32'(hOut), 32'd0);
      checkOutput("rExc", 32'(exc), 32'd0);
      checkOutput("rAcc", 32'(accept), 32'd0);
      doneCount = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) doneCount++;
      end
      checkOutput("rNoDone", 32'(doneCount), 32'd0);

      $display("[TB] negative tolerance");
      applyStimulus(0, 1, 16'h0040, '0, '0, '0, '0, '0);
      applyStimulus(1, 0, 16'h0000, {16'h0123, 16'h0456}, {16'h0123, 16'h0456},
                    16'hFFF0, 16'h0010, 16'h7000);
      waitDone(cyc);
      checkOutput("t6Acc", 32'(accept), 32'd1);
      checkOutput("t6H", 32'(hOut), 32'h0080);
      checkOutput("t6Exc", 32'(exc), 32'h1);
      checkOutput("t6Err", 32'(errMax), 32'h0000);

      $display("[TB] start and h_load while busy");
      applyStimulus(1, 0, 16'h0000, '0, '0, 16'h0020, 16'h0010, 16'h7000);
      start = 1'b1;
      hLoad = 1'b1;
      hIn = 16'h1234;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      hLoad = 1'b0;
      doneCount = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) doneCount++;
      end
      checkOutput("t7DoneCount", 32'(doneCount), 32'd1);
      checkOutput("t7H", 32'(hOut), 32'h0100);
      checkOutput("t7Busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
